oam_dma: RTL

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 107 ++++++++++
 1 files changed

// File: rtl/oam_dma.sv
// OAM DMA: a CPU write to P_DMA_REG stalls the CPU and copies one 256-byte page to P_OAM_PORT.
// Sequence is HALT (+ALIGN when r_odd) then 256 READ/WRITE pairs; the CPU bus passes through while idle.
module oam_dma #(
  parameter logic [15:0] P_DMA_REG  = 16'h4014,
  parameter logic [15:0] P_OAM_PORT = 16'h2004
) (
  input  logic        i_cpu_clk,
  input  logic        i_cpu_rstn,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_wn,
  input  logic [7:0]  i_cpu_wdata,
  input  logic [7:0]  i_bus_rdata,
  output logic [15:0] o_bus_addr,
  output logic        o_bus_wn,
  output logic [7:0]  o_bus_wdata,
  output logic        o_cpu_rdy,
  output logic        o_dma_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic [7:0] r_dbuf;
  logic       r_odd;
  logic       w_trigger;

  assign w_trigger = (r_state == S_IDLE) && (i_cpu_addr == P_DMA_REG) && !i_cpu_wn;

  always_ff @(posedge i_cpu_clk) begin
    if (!i_cpu_rstn) begin
      r_state <= S_IDLE;
      r_page  <= 8'h00;
      r_idx   <= 8'h00;
      r_dbuf  <= 8'h00;
      r_odd   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_odd   <= ~r_odd;
      if (w_trigger) begin
        r_page <= i_cpu_wdata;
        r_idx  <= 8'h00;
      end
      if (r_state == S_READ) begin
        r_dbuf <= i_bus_rdata;
      end
      // Index wraps to 0 on the last WRITE, leaving it ready for the next transfer.
      if (r_state == S_WRITE) begin
        r_idx <= r_idx + 8'h01;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    o_bus_addr  = i_cpu_addr;
    o_bus_wn    = i_cpu_wn;
    o_bus_wdata = i_cpu_wdata;
    o_cpu_rdy   = 1'b0;
    o_dma_busy  = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_cpu_rdy  = 1'b1;
        o_dma_busy = 1'b0;
        if (w_trigger) begin
          w_next = S_HALT;
        end
      end
      S_HALT: begin
        o_bus_addr  = 16'h0000;
        o_bus_wn    = 1'b1;
        o_bus_wdata = 8'h00;
        w_next      = r_odd ? S_ALIGN : S_READ;
      end
      S_ALIGN: begin
        o_bus_addr  = 16'h0000;
        o_bus_wn    = 1'b1;
        o_bus_wdata = 8'h00;
        w_next      = S_READ;
      end
      S_READ: begin
        o_bus_addr  = {r_page, r_idx};
        o_bus_wn    = 1'b1;
        o_bus_wdata = 8'h00;
        w_next      = S_WRITE;
      end
      S_WRITE: begin
        o_bus_addr  = P_OAM_PORT;
        o_bus_wn    = 1'b0;
        o_bus_wdata = r_dbuf;
        w_next      = (r_idx == 8'hFF) ? S_IDLE : S_READ;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
